gearbox_tx: RTL and testbench

- Tx gearbox: accepts 66-bit blocks (2-bit sync header plus 64-bit payload) from the PCS encoder/scrambler and emits one 64-bit word per clk to the PMA.
- 32 blocks (2112 bits) equal exactly 33 words, so the block deasserts ready_o for one cycle in every 33 to drain its residual buffer.
- Mirror of the Rx gearbox; uses the same bit ordering (header in block LSBs, word bit 0 transmitted first).

---
 rtl/gearbox_tx_pkg.sv | 24 ++
 rtl/gearbox_tx_if.sv | 25 ++
 rtl/gearbox_tx_shift.sv | 39 +++
 rtl/gearbox_tx.sv | 115 +++++++++++
 tb/tb_gearbox_tx.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/gearbox_tx_pkg.sv
// Shared gearbox constants, sync-header values and the tx operation decode type.
// Also used by the Rx gearbox; only HEAD_W=2 and DATA_W=64 are supported.
package gearbox_tx_pkg;

    localparam int HEAD_W  = 2;
    localparam int DATA_W  = 64;
    localparam int BLOCK_W = 66;
    localparam int SEQ_W   = 6;

    localparam logic [SEQ_W-1:0]  SEQ_DRAIN = 6'd32;
    localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b10;
    localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;

    typedef enum logic [1:0] {
        OP_STALL  = 2'd0,
        OP_ACCEPT = 2'd1,
        OP_DRAIN  = 2'd2
    } op_e;

    function automatic logic head_ok(input logic [HEAD_W-1:0] head);
        return (head == SYNC_DATA) || (head == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/gearbox_tx_if.sv
// Block-in / word-out bundle of the tx gearbox.
// GEARBOX_TX_HEAD_CHECK_EN adds the err_o sync-header error flag.
interface gearbox_tx_if;

    logic                              valid_i;
    logic [gearbox_tx_pkg::HEAD_W-1:0] head_i;
    logic [gearbox_tx_pkg::DATA_W-1:0] data_i;
    logic                              ready_o;
    logic                              valid_o;
    logic [gearbox_tx_pkg::DATA_W-1:0] data_o;
`ifdef GEARBOX_TX_HEAD_CHECK_EN
    logic                              err_o;

    modport master (output valid_i, head_i, data_i,
                    input  ready_o, valid_o, data_o, err_o);
    modport slave  (input  valid_i, head_i, data_i,
                    output ready_o, valid_o, data_o, err_o);
`else
    modport master (output valid_i, head_i, data_i,
                    input  ready_o, valid_o, data_o);
    modport slave  (input  valid_i, head_i, data_i,
                    output ready_o, valid_o, data_o);
`endif

endinterface

// File: rtl/gearbox_tx_shift.sv
// Combinational shift/mask datapath: merges the residual with the incoming block
// into the next PMA word and extracts the new residual.
module gearbox_tx_shift
    import gearbox_tx_pkg::*;
(
    input  logic [SEQ_W-1:0]   seq,
    input  logic [BLOCK_W-1:0] blk,
    input  logic [DATA_W-1:0]  res,
    output logic [DATA_W-1:0]  word,
    output logic [DATA_W-1:0]  res_nxt
);

    logic [6:0]        sh_s;
    logic [6:0]        rsh_s;
    logic [7:0]        keep_sh_s;
    logic [DATA_W-1:0] blk_shl_s;
    logic [DATA_W-1:0] blk_shr_s;
    logic [DATA_W-1:0] low_mask_s;
    logic [DATA_W-1:0] keep_mask_s;

    // Residual occupies 2*seq bits; masks keep stale upper residual bits out of the word.
    always_comb begin
        sh_s        = {seq, 1'b0};
        rsh_s       = 7'd64 - sh_s;
        keep_sh_s   = {1'b0, sh_s} + 8'd2;
        blk_shl_s   = blk[DATA_W-1:0] << sh_s;
        blk_shr_s   = DATA_W'(blk >> rsh_s);
        low_mask_s  = ~({DATA_W{1'b1}} << sh_s);
        keep_mask_s = ~({DATA_W{1'b1}} << keep_sh_s);
        if (seq >= SEQ_DRAIN) begin
            word    = res;
            res_nxt = {DATA_W{1'b0}};
        end else begin
            word    = blk_shl_s | (res & low_mask_s);
            res_nxt = blk_shr_s & keep_mask_s;
        end
    end

endmodule

// File: rtl/gearbox_tx.sv
// 66b -> 64b tx gearbox: 32 accepted blocks plus one drain cycle yield 33 PMA words.
// Define GEARBOX_TX_HEAD_CHECK_EN to add the registered err_o invalid-header flag.
module gearbox_tx
    import gearbox_tx_pkg::*;
(
    input  logic         clk,
    input  logic         nreset,
    gearbox_tx_if.slave  bus
);

    logic [SEQ_W-1:0]   seq_r;
    logic [SEQ_W-1:0]   seq_nxt_s;
    logic [DATA_W-1:0]  res_r;
    logic [DATA_W-1:0]  res_nxt_s;
    logic [DATA_W-1:0]  res_shift_s;
    logic [DATA_W-1:0]  word_s;
    logic [DATA_W-1:0]  data_r;
    logic [DATA_W-1:0]  data_nxt_s;
    logic               valid_r;
    logic               valid_nxt_s;
    logic               ready_s;
    logic [BLOCK_W-1:0] blk_s;
    op_e                op_s;
`ifdef GEARBOX_TX_HEAD_CHECK_EN
    logic               err_r;
    logic               err_nxt_s;
`endif

    assign ready_s = (seq_r != SEQ_DRAIN);
    assign blk_s   = {bus.data_i, bus.head_i};

    gearbox_tx_shift u_shift (
        .seq     (seq_r),
        .blk     (blk_s),
        .res     (res_r),
        .word    (word_s),
        .res_nxt (res_shift_s)
    );

    // Operation decode and next-state; a drain cycle ignores valid_i entirely.
    always_comb begin
        op_s        = OP_STALL;
        seq_nxt_s   = seq_r;
        res_nxt_s   = res_r;
        valid_nxt_s = 1'b0;
        data_nxt_s  = data_r;
        if (!ready_s) begin
            op_s = OP_DRAIN;
        end else if (bus.valid_i) begin
            op_s = OP_ACCEPT;
        end else begin
            op_s = OP_STALL;
        end
        case (op_s)
            OP_ACCEPT: begin
                seq_nxt_s   = seq_r + 6'd1;
                res_nxt_s   = res_shift_s;
                valid_nxt_s = 1'b1;
                data_nxt_s  = word_s;
            end
            OP_DRAIN: begin
                seq_nxt_s   = 6'd0;
                res_nxt_s   = res_shift_s;
                valid_nxt_s = 1'b1;
                data_nxt_s  = word_s;
            end
            default: begin
                seq_nxt_s   = seq_r;
                res_nxt_s   = res_r;
                valid_nxt_s = 1'b0;
                data_nxt_s  = data_r;
            end
        endcase
    end

`ifdef GEARBOX_TX_HEAD_CHECK_EN
    // Flag accepted blocks whose sync header is neither data nor control.
    always_comb begin
        if (op_s == OP_ACCEPT) begin
            err_nxt_s = !head_ok(bus.head_i);
        end else begin
            err_nxt_s = 1'b0;
        end
    end
`endif

    // State and output registers; reset drops any residual so the next block starts aligned.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            seq_r   <= 6'd0;
            res_r   <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
`ifdef GEARBOX_TX_HEAD_CHECK_EN
            err_r   <= 1'b0;
`endif
        end else begin
            seq_r   <= seq_nxt_s;
            res_r   <= res_nxt_s;
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
`ifdef GEARBOX_TX_HEAD_CHECK_EN
            err_r   <= err_nxt_s;
`endif
        end
    end

    assign bus.ready_o = ready_s;
    assign bus.valid_o = valid_r;
    assign bus.data_o  = data_r;
`ifdef GEARBOX_TX_HEAD_CHECK_EN
    assign bus.err_o   = err_r;
`endif

endmodule

// File: tb/tb_gearbox_tx.sv
// Directed bench for gearbox_tx: expected words come from a serial LSB-first bit-queue
// model of the block stream plus hand-computed values at the boundary steps.
module tb_gearbox_tx;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    gearbox_tx_if bus();

    gearbox_tx dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    bit          model_q[$];
    logic [63:0] last_data = 64'd0;
    logic [63:0] xdat;
    logic        exp_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict accept/drain from ready_o, then check outputs.
    task automatic tick(input logic v, input logic [1:0] h, input logic [63:0] d, input string tag);
        logic        rdy;
        logic        acc;
        logic [65:0] b;
        logic [63:0] w;
        bus.valid_i = v;
        bus.head_i  = h;
        bus.data_i  = d;
        @(negedge clk);
        rdy = bus.ready_o;
        acc = v && rdy;
        b   = {d, h};
        if (acc) begin
            for (int k = 0; k < 66; k++) model_q.push_back(b[k]);
        end
        @(posedge clk);
        #1;
        if (acc || !rdy) begin
            w = 64'd0;
            for (int k = 0; k < 64; k++) begin
                if (model_q.size() > 0) w[k] = model_q.pop_front();
            end
            last_data = w;
            chk({tag, " valid_o"}, {63'd0, bus.valid_o}, 64'd1);
        end else begin
            chk({tag, " valid_o"}, {63'd0, bus.valid_o}, 64'd0);
        end
        chk({tag, " data_o"}, bus.data_o, last_data);
`ifdef GEARBOX_TX_HEAD_CHECK_EN
        chk({tag, " err_o"}, {63'd0, bus.err_o}, {63'd0, acc && (h == 2'b00 || h == 2'b11)});
`endif
    endtask

    task automatic do_reset(input string tag);
        nreset      = 1'b0;
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " valid_o"}, {63'd0, bus.valid_o}, 64'd0);
        chk({tag, " data_o"}, bus.data_o, 64'd0);
        chk({tag, " ready_o"}, {63'd0, bus.ready_o}, 64'd1);
        nreset = 1'b1;
        model_q.delete();
        last_data = 64'd0;
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.head_i  = 2'b00;
        bus.data_i  = 64'd0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // A: continuous 01/zero blocks, drain every 33rd cycle
        for (int i = 0; i < 99; i++) begin
            exp_rdy = ((i % 33) == 32) ? 1'b0 : 1'b1;
            chk("A ready_o", {63'd0, bus.ready_o}, {63'd0, exp_rdy});
            tick(1'b1, 2'b01, 64'd0, "A");
            if (i == 0) chk("A first word", bus.data_o, 64'h0000_0000_0000_0001);
        end
        chk("A seq after 3 periods", {58'd0, dut.seq_r}, 64'd0);

        // B: 32 patterned blocks with alternating headers, then the drain word
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, {32'hA5A5_A5A5, i[31:0]}, "B");
        end
        chk("B drain ready_o", {63'd0, bus.ready_o}, 64'd0);
        tick(1'b0, 2'b00, 64'd0, "B drain");
        chk("B residue empty", 64'(model_q.size()), 64'd0);

        // C: stall three cycles at seq 5
        for (int i = 0; i < 5; i++) tick(1'b1, 2'b10, {32'h1234_5678, i[31:0]}, "C pre");
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, "C stall");
            chk("C seq held", {58'd0, dut.seq_r}, 64'd5);
        end
        for (int i = 5; i < 32; i++) tick(1'b1, 2'b01, {32'h9ABC_DEF0, i[31:0]}, "C post");
        tick(1'b0, 2'b00, 64'd0, "C drain");
        chk("C residue empty", 64'(model_q.size()), 64'd0);

        // D: block offered during drain is held and accepted next cycle
        for (int i = 0; i < 32; i++) tick(1'b1, 2'b01, {32'h0F0F_0F0F, i[31:0]}, "D fill");
        xdat = 64'hDEAD_BEEF_0123_4567;
        tick(1'b1, 2'b10, xdat, "D blocked");
        tick(1'b1, 2'b10, xdat, "D accept");
        chk("D aligned word", bus.data_o, {xdat[61:0], 2'b10});

        // E: reset mid-sequence at seq 17
        for (int i = 1; i < 17; i++) tick(1'b1, 2'b01, {32'h5555_AAAA, i[31:0]}, "E fill");
        chk("E seq before reset", {58'd0, dut.seq_r}, 64'd17);
        do_reset("E reset");
        xdat = 64'hC3C3_0000_FFFF_1234;
        tick(1'b1, 2'b01, xdat, "E accept");
        chk("E aligned word", bus.data_o, {xdat[61:0], 2'b01});

`ifdef GEARBOX_TX_HEAD_CHECK_EN
        // F: invalid sync headers flagged, valid one not
        tick(1'b1, 2'b11, 64'h1111_2222_3333_4444, "F h11");
        chk("F err h11", {63'd0, bus.err_o}, 64'd1);
        tick(1'b1, 2'b00, 64'h5555_6666_7777_8888, "F h00");
        chk("F err h00", {63'd0, bus.err_o}, 64'd1);
        tick(1'b1, 2'b10, 64'h9999_AAAA_BBBB_CCCC, "F h10");
        chk("F err h10", {63'd0, bus.err_o}, 64'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
